// File: rtl/muldiv_unit_if.sv
// Multiply/divide unit request and result bus.
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] srca;
  logic [WIDTH-1:0] srcb;
  logic             cancel;
  logic             hiwrite;
  logic             lowrite;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, srca, srcb, cancel, hiwrite, lowrite, wdata,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, srca, srcb, cancel, hiwrite, lowrite, wdata,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit with HI/LO result registers.
// Multiplies use shift-add and divides use restoring division, both on
// operand magnitudes; the signs are applied in a final FIX cycle.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           reset,
  muldiv_unit_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX
  } state_t;

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t             state, state_nxt;
  logic [CW-1:0]      count;
  logic [2*WIDTH-1:0] acc;       // mult: {partial, multiplier}; div: {rem, quot}
  logic [WIDTH-1:0]   opb;       // multiplicand or divisor magnitude
  logic               is_div;
  logic               neg_q;     // product / quotient negative
  logic               neg_r;     // remainder negative (dividend sign)
  logic               div_zero;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               done_q;

  logic               sgn, a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     shl;
  logic               div_ge;
  logic [WIDTH-1:0]   rem_sub;
  logic [2*WIDTH-1:0] step_acc;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quot, rem;
  logic [WIDTH-1:0]   res_hi, res_lo;

  // Operand sign stripping for signed ops
  always_comb begin
    sgn   = ~bus.op[0];
    a_neg = sgn & bus.srca[WIDTH-1];
    b_neg = sgn & bus.srcb[WIDTH-1];
    a_mag = a_neg ? -bus.srca : bus.srca;
    b_mag = b_neg ? -bus.srcb : bus.srcb;
  end

  // One radix-2 iteration: shift-add multiply or restoring divide step
  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
    shl      = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_ge   = shl >= {1'b0, opb};
    rem_sub  = shl[WIDTH-1:0] - opb;
    if (is_div) begin
      step_acc = div_ge ? {rem_sub, acc[WIDTH-2:0], 1'b1}
                        : {shl[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end else begin
      step_acc = {mul_sum, acc[WIDTH-1:1]};
    end
  end

  // Sign correction of the finished magnitude result.
  // Divide-by-zero leaves the dividend magnitude as remainder, so restoring
  // the dividend sign yields srca unchanged; only the quotient is forced.
  always_comb begin
    prod = neg_q ? -acc : acc;
    quot = acc[WIDTH-1:0];
    rem  = acc[2*WIDTH-1:WIDTH];
    if (is_div) begin
      res_lo = div_zero ? '1 : (neg_q ? -quot : quot);
      res_hi = neg_r ? -rem : rem;
    end else begin
      res_lo = prod[WIDTH-1:0];
      res_hi = prod[2*WIDTH-1:WIDTH];
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (bus.start && !bus.cancel) state_nxt = RUN;
      RUN: begin
        if (bus.cancel)         state_nxt = IDLE;
        else if (count == LAST) state_nxt = FIX;
      end
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand latch, iteration datapath and HI/LO registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      count    <= '0;
      acc      <= '0;
      opb      <= '0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.hiwrite) hi_q <= bus.wdata;
          if (bus.lowrite) lo_q <= bus.wdata;
          if (bus.start && !bus.cancel) begin
            is_div   <= bus.op[1];
            neg_q    <= a_neg ^ b_neg;
            neg_r    <= a_neg;
            div_zero <= (bus.srcb == '0);
            count    <= '0;
            opb      <= bus.op[1] ? b_mag : a_mag;
            acc      <= {{WIDTH{1'b0}}, (bus.op[1] ? a_mag : b_mag)};
          end
        end
        RUN: begin
          if (!bus.cancel) begin
            acc   <= step_acc;
            count <= count + CW'(1);
          end
        end
        FIX: begin
          if (!bus.cancel) begin
            hi_q   <= res_hi;
            lo_q   <= res_lo;
            done_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (state != IDLE);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit at WIDTH=32: a transaction-level
// reference model checked every cycle, plus directed literal vectors.
module tb_muldiv_unit;

  localparam int W = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  muldiv_unit_if #(.WIDTH(W)) bus();

  muldiv_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b, hi, lo;
  } vec_t;

  vec_t vecs [12] = '{
    '{2'b00, 32'hFFFFFFFF, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFD},
    '{2'b01, 32'hFFFFFFFF, 32'h00000003, 32'h00000002, 32'hFFFFFFFD},
    '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD},
    '{2'b11, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003},
    '{2'b11, 32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF},
    '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000},
    '{2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD},
    '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000},
    '{2'b10, 32'hFFFFFF00, 32'h00000000, 32'hFFFFFF00, 32'hFFFFFFFF},
    '{2'b00, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001},
    '{2'b11, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF},
    '{2'b10, 32'h80000000, 32'h00000002, 32'h00000000, 32'hC0000000}
  };

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference arithmetic: {hi, lo} for one operation
  function automatic logic [63:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
    logic [63:0] ea, eb;
    int sa, sb;
    case (op)
      2'b00: begin
        ea = {{32{a[31]}}, a};
        eb = {{32{b[31]}}, b};
        return ea * eb;
      end
      2'b01: begin
        ea = {32'h0, a};
        eb = {32'h0, b};
        return ea * eb;
      end
      2'b10: begin
        if (b == 32'h0) return {a, 32'hFFFFFFFF};
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
        sa = a;
        sb = b;
        return {32'(sa % sb), 32'(sa / sb)};
      end
      default: begin
        if (b == 32'h0) return {a, 32'hFFFFFFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  // Transaction-level model: result lands WIDTH+1 edges after acceptance
  logic [31:0] m_hi, m_lo, r_hi, r_lo;
  bit          m_busy, m_done;
  int          m_cnt;

  always @(posedge clk) begin
    if (reset === 1'b0) begin
      m_hi = '0; m_lo = '0; m_busy = 1'b0; m_done = 1'b0; m_cnt = 0;
    end else begin
      m_done = 1'b0;
      if (!m_busy) begin
        if (bus.hiwrite) m_hi = bus.wdata;
        if (bus.lowrite) m_lo = bus.wdata;
        if (bus.start && !bus.cancel) begin
          {r_hi, r_lo} = ref_result(bus.op, bus.srca, bus.srcb);
          m_busy = 1'b1;
          m_cnt  = W + 1;
        end
      end else if (bus.cancel) begin
        m_busy = 1'b0;
      end else begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_hi = r_hi; m_lo = r_lo; m_done = 1'b1; m_busy = 1'b0;
        end
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_busy", 32'(bus.busy), 32'(m_busy));
      chk("cyc_done", 32'(bus.done), 32'(m_done));
      chk("cyc_hi", bus.hi, m_hi);
      chk("cyc_lo", bus.lo, m_lo);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo, input string nm);
    int n;
    bus.op = op; bus.srca = a; bus.srcb = b; bus.start = 1'b1;
    n = 0;
    do begin
      tick();
      bus.start = 1'b0;
      n++;
    end while (bus.done !== 1'b1 && n < 100);
    chk({nm, "_latency"}, 32'(n), 32'd34);
    chk({nm, "_hi"}, bus.hi, ehi);
    chk({nm, "_lo"}, bus.lo, elo);
    tick();
  endtask

  task automatic cancel_at(input int nb, input string nm);
    int nd;
    bus.hiwrite = 1'b1; bus.lowrite = 1'b1; bus.wdata = 32'hAAAA0000;
    tick();
    bus.hiwrite = 1'b0; bus.lowrite = 1'b0;
    bus.op = 2'b00; bus.srca = 32'hFFFFFFFF; bus.srcb = 32'h3; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (nb - 1) tick();
    bus.cancel = 1'b1;
    tick();
    bus.cancel = 1'b0;
    chk({nm, "_busy"}, 32'(bus.busy), 32'd0);
    chk({nm, "_done"}, 32'(bus.done), 32'd0);
    chk({nm, "_hi"}, bus.hi, 32'hAAAA0000);
    chk({nm, "_lo"}, bus.lo, 32'hAAAA0000);
    nd = 0;
    repeat (40) begin
      tick();
      if (bus.done === 1'b1) nd++;
    end
    chk({nm, "_nodone"}, 32'(nd), 32'd0);
    run_op(2'b00, 32'hFFFFFFFF, 32'h3, 32'hFFFFFFFF, 32'hFFFFFFFD, {nm, "_restart"});
  endtask

  initial begin
    #300000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int n, nd;
    reset = 1'b0;
    bus.start = 1'b0; bus.cancel = 1'b0; bus.hiwrite = 1'b0; bus.lowrite = 1'b0;
    bus.op = 2'b00; bus.srca = '0; bus.srcb = '0; bus.wdata = '0;
    tick();
    chk_en = 1'b1;

    // Reset overrides start and writes
    bus.start = 1'b1; bus.hiwrite = 1'b1; bus.lowrite = 1'b1; bus.wdata = 32'h5A5A5A5A;
    tick();
    bus.start = 1'b0; bus.hiwrite = 1'b0; bus.lowrite = 1'b0;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_hi", bus.hi, 32'h0);
    chk("rst_lo", bus.lo, 32'h0);
    reset = 1'b1;
    tick();

    // Directed arithmetic vectors
    for (int i = 0; i < 12; i++)
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, $sformatf("vec%0d", i));

    // Start together with cancel in IDLE is ignored
    bus.start = 1'b1; bus.cancel = 1'b1;
    tick();
    bus.start = 1'b0; bus.cancel = 1'b0;
    chk("startcancel_busy", 32'(bus.busy), 32'd0);

    // Cancel in RUN (10th busy cycle) and in FIX (last busy cycle)
    cancel_at(10, "cancel_run");
    cancel_at(33, "cancel_fix");

    // Writes alongside an accepted start: applied, then overwritten by result
    bus.hiwrite = 1'b1; bus.lowrite = 1'b1; bus.wdata = 32'h12345678;
    bus.op = 2'b01; bus.srca = 32'h00010000; bus.srcb = 32'h00010000; bus.start = 1'b1;
    tick();
    bus.hiwrite = 1'b0; bus.lowrite = 1'b0; bus.start = 1'b0;
    chk("wrstart_hi", bus.hi, 32'h12345678);
    chk("wrstart_lo", bus.lo, 32'h12345678);
    n = 1;
    while (bus.done !== 1'b1 && n < 100) begin tick(); n++; end
    chk("wrstart_latency", 32'(n), 32'd34);
    chk("wrstart_res_hi", bus.hi, 32'h00000001);
    chk("wrstart_res_lo", bus.lo, 32'h00000000);
    tick();

    // Start and mthi while busy are ignored
    bus.op = 2'b00; bus.srca = 32'hFFFFFFF9; bus.srcb = 32'h6; bus.start = 1'b1;
    tick();
    bus.op = 2'b11; bus.srca = 32'd100; bus.srcb = 32'd7;
    bus.hiwrite = 1'b1; bus.wdata = 32'hDEADBEEF;
    tick();
    tick();
    bus.start = 1'b0; bus.hiwrite = 1'b0;
    n = 3; nd = 0;
    while (bus.done !== 1'b1 && n < 100) begin tick(); n++; end
    chk("busyign_latency", 32'(n), 32'd34);
    chk("busyign_hi", bus.hi, 32'hFFFFFFFF);
    chk("busyign_lo", bus.lo, 32'hFFFFFFD6);
    if (bus.done === 1'b1) nd++;
    repeat (40) begin
      tick();
      if (bus.done === 1'b1) nd++;
    end
    chk("busyign_ndone", 32'(nd), 32'd1);

    // Reset during the 5th RUN cycle discards the operation
    bus.hiwrite = 1'b1; bus.lowrite = 1'b1; bus.wdata = 32'h11111111;
    tick();
    bus.hiwrite = 1'b0; bus.lowrite = 1'b0;
    bus.op = 2'b11; bus.srca = 32'd1000; bus.srcb = 32'd7; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (4) tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_done", 32'(bus.done), 32'd0);
    chk("midrst_hi", bus.hi, 32'h0);
    chk("midrst_lo", bus.lo, 32'h0);
    nd = 0;
    repeat (40) begin
      tick();
      if (bus.done === 1'b1) nd++;
    end
    chk("midrst_nodone", 32'(nd), 32'd0);
    run_op(2'b11, 32'd1000, 32'd7, 32'd6, 32'd142, "midrst_restart");

    repeat (2) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter: WIDTH, default 32, operand/HI/LO width; SHALL be >= 4 and even.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-low; reset=0 at a rising edge resets all state.
REQ-004 start  input  1  request a new operation; sampled only in IDLE.
REQ-005 op  input  2  00 mult (signed), 01 multu, 10 div (signed), 11 divu.
REQ-006 srca  input  WIDTH  multiplicand or dividend.
REQ-007 srcb  input  WIDTH  multiplier or divisor.
REQ-008 cancel  input  1  abort the in-flight operation (pipeline flush).
REQ-009 hiwrite  input  1  mthi: load hi from wdata.
REQ-010 lowrite  input  1  mtlo: load lo from wdata.
REQ-011 wdata  input  WIDTH  data for mthi/mtlo.
REQ-012 busy  output  1  high while in RUN or FIX; the hazard unit stalls on it.
REQ-013 done  output  1  one-cycle pulse when hi/lo receive a new result.
REQ-014 hi  output  WIDTH  HI register: product upper half or remainder.
REQ-015 lo  output  WIDTH  LO register: product lower half or quotient.

Function
REQ-016 FSM states SHALL be IDLE, RUN, and FIX; busy=1 exactly in RUN and FIX.
REQ-017 IDLE with start=1 and cancel=0 at edge k: latch op; latch operand magnitudes (two's-complement absolute value for signed ops, raw for unsigned); latch the result signs; clear the iteration counter; go to RUN.
REQ-018 RUN: one radix-2 step per cycle (shift-add multiply, restoring divide); after WIDTH steps go to FIX.
REQ-019 FIX: apply sign correction, write hi/lo at edge k+WIDTH+1, return to IDLE; done=1 during the following cycle only.
REQ-020 Latency: new hi/lo and done=1 SHALL be visible in the cycle after edge k+WIDTH+1; start is accepted again in that same cycle.
REQ-021 Multiply: {hi,lo} = full 2*WIDTH-bit product, signed or unsigned per op.
REQ-022 Divide: lo = quotient, truncated toward zero; hi = remainder, taking the sign of the dividend.
REQ-023 Divide by zero: lo = all ones, hi = srca as latched; full latency and done still apply.
REQ-024 Signed overflow (most-negative / -1): lo = most-negative, hi = 0.
REQ-025 start while busy SHALL be ignored, with no queueing.
REQ-026 hiwrite/lowrite SHALL take effect at the next edge only in IDLE; they are ignored while busy.
REQ-027 hiwrite/lowrite together with an accepted start: the write is applied, and the result later overwrites it.
REQ-028 cancel in RUN or FIX: return to IDLE at the next edge; hi/lo unchanged; no done.
REQ-029 cancel with start in IDLE: start is ignored.
REQ-030 hi/lo change only on reset, mthi/mtlo, or FIX completion.

Reset
REQ-031 reset=0 SHALL force state=IDLE, busy=0, done=0, hi=0, lo=0, and counter=0, overriding start, cancel, and writes.
REQ-032 reset asserted mid-operation SHALL discard the operation with no done pulse; the first start after release is accepted normally.

Verification (WIDTH=32)
REQ-033 mult 0xFFFFFFFF x 0x00000003 -> hi=0xFFFFFFFF, lo=0xFFFFFFFD, done 34 cycles after the start cycle; multu with the same operands -> hi=0x00000002, lo=0xFFFFFFFD.
REQ-034 div 0xFFFFFFF9 / 0x00000002 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; divu 7 / 2 -> lo=3, hi=1.
REQ-035 divu 0x00001234 / 0 -> lo=0xFFFFFFFF, hi=0x00001234; div 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-036 hi=0xAAAA0000 preloaded via mthi, then mult started, then cancel on the 10th busy cycle -> busy=0 next cycle, hi=0xAAAA0000 kept, no done; an immediate restart completes correctly.
REQ-037 start pulsed again while busy, and hiwrite while busy -> both ignored; a single done; hi/lo hold the first result.
REQ-038 reset=0 on the 5th RUN cycle -> next cycle busy=0, done=0, hi=lo=0; no done afterwards.
